shot_scoreboard_mux: RTL and testbench

Parametrised scoreboard and output sequencer for the artillery game top level. It replaces the fixed five-way one-hot output mux with an N-channel, W-bit registered mux that supports manual one-hot selection and an auto-scan mode. It counts shots and hits from the trajectory calculator's `result_valid`/`hit` pair and flags game over after a configurable number of shots. It sits between the game datapath (cannon position, aim, target x/y, trajectory position) and `uo_out`.

---
 rtl/shot_scoreboard_mux.sv | 125 ++++++++++++
 tb/tb_shot_scoreboard_mux.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_scoreboard_mux.sv
// Shot/hit scoreboard plus registered N-channel output mux with manual one-hot select
// and an auto-scan mode that appends the score as a virtual last channel.
module shot_scoreboard_mux #(
    parameter int W          = 5,
    parameter int N          = 5,
    parameter int SCORE_W    = 4,
    parameter int SHOTS_MAX  = 10,
    parameter int DWELL      = 4,
    localparam int CW        = $clog2(N + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [N*W-1:0]     ch_data,
    input  logic [N-1:0]       sel,
    input  logic               auto_mode,
    input  logic               result_valid,
    input  logic               hit,
    input  logic               new_game,
    output logic [W-1:0]       out_data,
    output logic [CW-1:0]      out_ch,
    output logic               out_valid,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         shots,
    output logic               last_hit,
    output logic               game_over
);

    localparam int                 DCW        = $clog2(DWELL + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [7:0]         SHOTS_PREV = 8'(SHOTS_MAX - 1);

    logic           rv_q;
    logic           auto_q;
    logic [CW-1:0]  scan_idx;
    logic [DCW-1:0] dwell_cnt;
    logic [CW-1:0]  nxt_idx;
    logic [DCW-1:0] nxt_cnt;
    logic [W-1:0]   nxt_data;
    logic [CW-1:0]  nxt_ch;
    logic           nxt_valid;
    logic           shot_ev;

    assign shot_ev = result_valid & ~rv_q & ~game_over;

    // Scan position: entering auto mode restarts at channel 0 as the first of DWELL cycles.
    always_comb begin
        nxt_idx = '0;
        nxt_cnt = '0;
        if (auto_mode) begin
            if (!auto_q) begin
                nxt_idx = '0;
                nxt_cnt = DCW'(1);
            end else if (dwell_cnt >= DCW'(DWELL)) begin
                nxt_idx = (scan_idx == CW'(N)) ? '0 : scan_idx + CW'(1);
                nxt_cnt = DCW'(1);
            end else begin
                nxt_idx = scan_idx;
                nxt_cnt = dwell_cnt + DCW'(1);
            end
        end
    end

    always_comb begin
        nxt_data  = '0;
        nxt_ch    = '0;
        nxt_valid = 1'b0;
        if (auto_mode) begin
            nxt_ch    = nxt_idx;
            nxt_valid = 1'b1;
            if (nxt_idx == CW'(N)) begin
                nxt_data = W'(score);
            end else begin
                for (int c = 0; c < N; c++) begin
                    if (nxt_idx == CW'(c)) nxt_data = ch_data[c*W +: W];
                end
            end
        end else if ($onehot(sel)) begin
            nxt_valid = 1'b1;
            for (int c = 0; c < N; c++) begin
                if (sel[c]) begin
                    nxt_data = ch_data[c*W +: W];
                    nxt_ch   = CW'(c);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_q      <= 1'b0;
            auto_q    <= 1'b0;
            scan_idx  <= '0;
            dwell_cnt <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            score     <= '0;
            shots     <= '0;
            last_hit  <= 1'b0;
            game_over <= 1'b0;
        end else if (ena) begin
            rv_q      <= result_valid;
            auto_q    <= auto_mode;
            scan_idx  <= nxt_idx;
            dwell_cnt <= nxt_cnt;
            out_data  <= nxt_data;
            out_ch    <= nxt_ch;
            out_valid <= nxt_valid;
            // A clear on the same cycle as a shot discards that shot.
            if (new_game) begin
                score     <= '0;
                shots     <= '0;
                last_hit  <= 1'b0;
                game_over <= 1'b0;
            end else if (shot_ev) begin
                shots    <= shots + 8'd1;
                last_hit <= hit;
                if (hit && score != SCORE_MAX) score <= score + SCORE_W'(1);
                if (shots == SHOTS_PREV) game_over <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shot_scoreboard_mux.sv
// Randomised bench for shot_scoreboard_mux against a cycle-count based behavioural model,
// plus literal checks of the documented scenarios.
module tb_shot_scoreboard_mux;

    localparam int W         = 5;
    localparam int N         = 5;
    localparam int SCORE_W   = 2;
    localparam int SHOTS_MAX = 10;
    localparam int DWELL     = 4;
    localparam int CW        = $clog2(N + 1);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ena;
    logic [N*W-1:0]     ch_data;
    logic [N-1:0]       sel;
    logic               auto_mode;
    logic               result_valid;
    logic               hit;
    logic               new_game;
    logic [W-1:0]       out_data;
    logic [CW-1:0]      out_ch;
    logic               out_valid;
    logic [SCORE_W-1:0] score;
    logic [7:0]         shots;
    logic               last_hit;
    logic               game_over;

    shot_scoreboard_mux #(
        .W(W), .N(N), .SCORE_W(SCORE_W), .SHOTS_MAX(SHOTS_MAX), .DWELL(DWELL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ch_data(ch_data), .sel(sel),
        .auto_mode(auto_mode), .result_valid(result_valid), .hit(hit),
        .new_game(new_game), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .score(score), .shots(shots),
        .last_hit(last_hit), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the scan position is derived from the number of enabled
    // cycles spent in auto mode since it was entered.
    int m_score = 0, m_shots = 0, m_last = 0, m_go = 0, m_rvq = 0;
    int m_prev_auto = 0, m_t = 0;
    int e_data = 0, e_ch = 0, e_valid = 0;

    function automatic int chan(input int c);
        return int'(ch_data[c*W +: W]);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_score = 0; m_shots = 0; m_last = 0; m_go = 0; m_rvq = 0;
                m_prev_auto = 0; m_t = 0;
                e_data = 0; e_ch = 0; e_valid = 0;
            end else if (ena) begin
                if (auto_mode) begin
                    int k;
                    m_t     = m_prev_auto ? m_t + 1 : 0;
                    k       = (m_t / DWELL) % (N + 1);
                    e_ch    = k;
                    e_valid = 1;
                    e_data  = (k == N) ? m_score : chan(k);
                end else begin
                    e_ch = 0; e_data = 0; e_valid = 0;
                    if ($countones(sel) == 1) begin
                        for (int c = 0; c < N; c++) begin
                            if (sel[c]) begin
                                e_ch = c; e_data = chan(c); e_valid = 1;
                            end
                        end
                    end
                end
                m_prev_auto = auto_mode ? 1 : 0;
                if (new_game) begin
                    m_score = 0; m_shots = 0; m_last = 0; m_go = 0;
                end else if (result_valid && m_rvq == 0 && m_go == 0) begin
                    m_shots++;
                    m_last = hit ? 1 : 0;
                    if (hit && m_score < (1 << SCORE_W) - 1) m_score++;
                    if (m_shots == SHOTS_MAX) m_go = 1;
                end
                m_rvq = result_valid ? 1 : 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("out_data", out_data, e_data);
                chk("out_ch", out_ch, e_ch);
                chk("out_valid", out_valid, e_valid);
                chk("score", score, m_score);
                chk("shots", shots, m_shots);
                chk("last_hit", last_hit, m_last);
                chk("game_over", game_over, m_go);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int c, input int v);
        ch_data[c*W +: W] = W'(v);
    endtask

    task automatic pulse(input bit h, input int len);
        result_valid = 1'b1;
        hit          = h;
        cyc(len);
        result_valid = 1'b0;
        cyc(1);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; ch_data = '0; sel = '0; auto_mode = 1'b0;
        result_valid = 1'b0; hit = 1'b0; new_game = 1'b0;
        cyc(3);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_score", score, 0);
        chk("rst_shots", shots, 0);
        chk("rst_game_over", game_over, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        set_ch(2, 17);
        sel = 5'b00100;
        cyc(1);
        chk("man_data", out_data, 17);
        chk("man_ch", out_ch, 2);
        chk("man_valid", out_valid, 1);
        sel = 5'b00110;
        cyc(1);
        chk("multi_data", out_data, 0);
        chk("multi_valid", out_valid, 0);

        for (int i = 0; i < 3; i++) pulse(1'b1, 3);
        for (int i = 0; i < 2; i++) pulse(1'b0, 3);
        chk("hits_shots", shots, 5);
        chk("hits_score", score, 3);
        chk("hits_last", last_hit, 0);

        for (int c = 0; c < N; c++) set_ch(c, c + 1);
        sel       = '0;
        auto_mode = 1'b1;
        cyc(1);
        chk("auto_first_ch", out_ch, 0);
        chk("auto_first_data", out_data, 1);
        cyc(20);
        chk("auto_vch", out_ch, 5);
        chk("auto_vdata", out_data, 3);
        cyc(4);
        chk("auto_wrap", out_ch, 0);

        cyc(6);
        auto_mode = 1'b0;
        cyc(1);
        auto_mode = 1'b1;
        cyc(1);
        chk("reentry_ch0", out_ch, 0);
        cyc(3);
        chk("reentry_dwell", out_ch, 0);
        cyc(1);
        chk("reentry_ch1", out_ch, 1);

        new_game = 1'b1;
        cyc(1);
        new_game = 1'b0;
        chk("ng_shots", shots, 0);
        for (int i = 0; i < 9; i++) pulse(bit'(i % 2), 2);
        chk("nine_go", game_over, 0);
        result_valid = 1'b1;
        hit          = 1'b1;
        cyc(1);
        chk("tenth_shots", shots, 10);
        chk("tenth_go", game_over, 1);
        chk("sat_score", score, 3);
        result_valid = 1'b0;
        cyc(1);
        pulse(1'b1, 2);
        chk("eleventh_shots", shots, 10);
        new_game = 1'b1;
        cyc(1);
        new_game = 1'b0;
        chk("clr_shots", shots, 0);
        chk("clr_go", game_over, 0);
        chk("clr_score", score, 0);
        pulse(1'b0, 2);
        chk("after_clr_shots", shots, 1);

        result_valid = 1'b1;
        new_game     = 1'b1;
        cyc(1);
        new_game = 1'b0;
        chk("simul_shots", shots, 0);
        cyc(3);
        result_valid = 1'b0;
        cyc(1);
        chk("simul_held", shots, 0);

        ena          = 1'b0;
        result_valid = 1'b1;
        cyc(3);
        chk("ena_off_shots", shots, 0);
        ena = 1'b1;
        cyc(2);
        chk("ena_on_shots", shots, 1);
        result_valid = 1'b0;
        cyc(1);
        chk("ena_once", shots, 1);

        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                #2 rst_n = 1'b0;
            end
            if (i == 302) rst_n = 1'b1;
            ena = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0) result_valid = ~result_valid;
            hit      = 1'($urandom);
            new_game = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) auto_mode = ~auto_mode;
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) sel = N'(1) << $urandom_range(0, N - 1);
                else sel = N'($urandom);
            end
            for (int c = 0; c < N; c++) set_ch(c, int'($urandom_range(0, (1 << W) - 1)));
            cyc(1);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
